// File: rtl/io_simple_module_param.sv
// io_simple_module_param
//   Parametrised sample buffer. It holds DEPTH entries of WIDTH bits, is read through a
//   first-word-fall-through port, and keeps a running reduction over the buffered samples.
//   Ports:
//     clk   - clock, rising edge
//     rst   - synchronous active-low reset
//     en    - push strobe, qualifies data
//     data  - sample to push
//     rd    - pop request
//     dout  - head-of-buffer sample, valid while res1=1 (0 when empty)
//     res1  - buffer not empty
//     res2  - reduction flag: acc >= THRESH (MODE 0) or acc != 0 (MODE 1)
//     fdbk  - buffer full, backpressure to producer
//     acc   - running sum (MODE 0) or XOR (MODE 1) over buffer contents
//     ovf   - sticky: push attempted while full
module io_simple_module_param #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned MODE   = 0,
   parameter int unsigned THRESH = 16,
   localparam int unsigned ACC_W = WIDTH + $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] data,
   input  logic             rd,
   output logic [WIDTH-1:0] dout,
   output logic             res1,
   output logic             res2,
   output logic             fdbk,
   output logic [ACC_W-1:0] acc,
   output logic             ovf
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

   state_e           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push, pop;

   // fdbk is a registered state decode, so a full buffer refuses a push even when a pop
   // happens in the same cycle.
   assign push = en & ~fdbk;
   assign pop  = rd & res1;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty: begin
            if (push) state_d = StPartial;
         end
         StPartial: begin
            if (push && !pop && count_q == CNT_W'(DEPTH - 1)) begin
               state_d = StFull;
            end else if (pop && !push && count_q == CNT_W'(1)) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            if (pop) state_d = StPartial;
         end
         default: state_d = StEmpty;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      res1 = 1'b0;
      fdbk = 1'b0;
      unique case (state_q)
         StEmpty:   begin res1 = 1'b0; fdbk = 1'b0; end
         StPartial: begin res1 = 1'b1; fdbk = 1'b0; end
         StFull:    begin res1 = 1'b1; fdbk = 1'b1; end
         default:   begin res1 = 1'b0; fdbk = 1'b0; end
      endcase
   end

   // Count and reduction next-state
   always_comb begin
      count_d = count_q;
      if (push && !pop) count_d = count_q + CNT_W'(1);
      if (pop && !push) count_d = count_q - CNT_W'(1);

      acc_d = acc_q;
      if (MODE == 0) begin
         if (push) acc_d = acc_d + ACC_W'(data);
         if (pop)  acc_d = acc_d - ACC_W'(dout);
      end else begin
         if (push) acc_d = acc_d ^ ACC_W'(data);
         if (pop)  acc_d = acc_d ^ ACC_W'(dout);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         acc_q   <= acc_d;
         if (en && fdbk) ovf_q <= 1'b1;
      end
   end

   // Storage is not reset; a push is gated by rst so the reset-cycle sample is dropped.
   always_ff @(posedge clk) begin
      if (rst && push) mem[wr_ptr_q] <= data;
   end

   // Gate with res1 so stale storage never shows after reset or drain.
   assign dout = res1 ? mem[rd_ptr_q] : '0;
   assign acc  = acc_q;
   assign ovf  = ovf_q;
   assign res2 = (MODE == 0) ? (acc_q >= ACC_W'(THRESH)) : (acc_q != '0);

endmodule

// File: tb/tb_io_simple_module_param.sv
module tb_io_simple_module_param;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, rd, en1, rd1;
   logic [7:0]  data, data1;
   logic [7:0]  dout, dout1;
   logic        res1, res2, fdbk, ovf;
   logic        res1_1, res2_1, fdbk_1, ovf_1;
   logic [10:0] acc, acc1;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] sb [$];
   bit         m_ovf;

   typedef struct {
      bit          rst_before;
      bit          e;
      logic [7:0]  d;
      bit          r;
      logic [7:0]  x_dout;
      bit          x_res1;
      bit          x_fdbk;
      bit          x_res2;
      bit          x_ovf;
      logic [10:0] x_acc;
   } vec_t;

   vec_t vec [16];

   io_simple_module_param #(.WIDTH(8), .DEPTH(4), .MODE(0), .THRESH(16)) u_sum (
      .clk(clk), .rst(rst), .en(en), .data(data), .rd(rd), .dout(dout), .res1(res1),
      .res2(res2), .fdbk(fdbk), .acc(acc), .ovf(ovf)
   );

   io_simple_module_param #(.WIDTH(8), .DEPTH(4), .MODE(1), .THRESH(16)) u_xor (
      .clk(clk), .rst(rst), .en(en1), .data(data1), .rd(rd1), .dout(dout1), .res1(res1_1),
      .res2(res2_1), .fdbk(fdbk_1), .acc(acc1), .ovf(ovf_1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change on the falling edge; checks happen on the following falling edge.
   task automatic step(input bit e, input logic [7:0] d, input bit r);
      int n;
      int sum;
      logic [7:0] exp_d;
      n = sb.size();
      en = e; data = d; rd = r;
      if (r && n > 0) begin
         exp_d = sb.pop_front();
         chk("dout_at_pop", {24'h0, dout}, {24'h0, exp_d});
      end
      if (e && n == DEPTH) m_ovf = 1'b1;
      if (e && n < DEPTH) sb.push_back(d);
      @(posedge clk);
      @(negedge clk);
      en = 1'b0; rd = 1'b0;
      sum = 0;
      foreach (sb[i]) sum += int'(sb[i]);
      chk("res1_model", {31'h0, res1}, {31'h0, sb.size() > 0});
      chk("fdbk_model", {31'h0, fdbk}, {31'h0, sb.size() == DEPTH});
      chk("ovf_model", {31'h0, ovf}, {31'h0, m_ovf});
      chk("acc_model", {21'h0, acc}, sum);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      sb.delete();
      m_ovf = 1'b0;
   endtask

   task automatic step1(input bit e, input logic [7:0] d, input bit r);
      en1 = e; data1 = d; rd1 = r;
      @(posedge clk);
      @(negedge clk);
      en1 = 1'b0; rd1 = 1'b0;
   endtask

   initial begin
      rst = 1'b0; en = 0; rd = 0; data = 0; en1 = 0; rd1 = 0; data1 = 0;
      m_ovf = 1'b0;

      //          rst e  d      r  dout   r1 fb r2 ov acc
      vec[0]  = '{0, 1, 8'd3,  0, 8'd3,  1, 0, 0, 0, 11'd3};
      vec[1]  = '{0, 1, 8'd5,  0, 8'd3,  1, 0, 0, 0, 11'd8};
      vec[2]  = '{0, 1, 8'd7,  0, 8'd3,  1, 0, 0, 0, 11'd15};
      vec[3]  = '{0, 1, 8'd9,  0, 8'd3,  1, 1, 1, 0, 11'd24};
      vec[4]  = '{0, 1, 8'hFF, 0, 8'd3,  1, 1, 1, 1, 11'd24};
      vec[5]  = '{0, 0, 8'd0,  1, 8'd5,  1, 0, 1, 1, 11'd21};
      vec[6]  = '{0, 0, 8'd0,  1, 8'd7,  1, 0, 1, 1, 11'd16};
      vec[7]  = '{0, 0, 8'd0,  1, 8'd9,  1, 0, 0, 1, 11'd9};
      vec[8]  = '{0, 0, 8'd0,  1, 8'd0,  0, 0, 0, 1, 11'd0};
      vec[9]  = '{0, 0, 8'd0,  1, 8'd0,  0, 0, 0, 1, 11'd0};
      vec[10] = '{1, 1, 8'd10, 0, 8'd10, 1, 0, 0, 0, 11'd10};
      vec[11] = '{0, 1, 8'd20, 0, 8'd10, 1, 0, 1, 0, 11'd30};
      vec[12] = '{0, 1, 8'd30, 1, 8'd20, 1, 0, 1, 0, 11'd50};
      vec[13] = '{0, 1, 8'd40, 0, 8'd20, 1, 0, 1, 0, 11'd90};
      vec[14] = '{0, 1, 8'd50, 0, 8'd20, 1, 1, 1, 0, 11'd140};
      vec[15] = '{0, 1, 8'd60, 1, 8'd30, 1, 0, 1, 1, 11'd120};

      // Reset then idle
      @(negedge clk);
      do_reset(2);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("idle_outputs", {19'h0, dout, res1, res2, fdbk, ovf},
             32'h0);
         chk("idle_acc", {21'h0, acc}, 32'h0);
      end
      chk("idle_xor_outputs", {8'h0, dout1, acc1, res1_1, res2_1, fdbk_1, ovf_1}, 32'h0);

      // Table-driven sequence: fill, overflow, drain, idle pop, concurrent push/pop
      foreach (vec[i]) begin
         if (vec[i].rst_before) do_reset(1);
         step(vec[i].e, vec[i].d, vec[i].r);
         chk($sformatf("v%0d_dout", i), {24'h0, dout}, {24'h0, vec[i].x_dout});
         chk($sformatf("v%0d_res1", i), {31'h0, res1}, {31'h0, vec[i].x_res1});
         chk($sformatf("v%0d_fdbk", i), {31'h0, fdbk}, {31'h0, vec[i].x_fdbk});
         chk($sformatf("v%0d_res2", i), {31'h0, res2}, {31'h0, vec[i].x_res2});
         chk($sformatf("v%0d_ovf", i), {31'h0, ovf}, {31'h0, vec[i].x_ovf});
         chk($sformatf("v%0d_acc", i), {21'h0, acc}, {21'h0, vec[i].x_acc});
      end

      // Drain remaining through the scoreboard
      while (sb.size() > 0) step(1'b0, 8'h0, 1'b1);
      chk("drained_res1", {31'h0, res1}, 32'h0);

      // Reset mid-fill with a push in the reset cycle
      do_reset(1);
      step(1'b1, 8'hA1, 1'b0);
      step(1'b1, 8'hA2, 1'b0);
      rst = 1'b0; en = 1'b1; data = 8'h77;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0; rst = 1'b1;
      sb.delete(); m_ovf = 1'b0;
      chk("midrst_res1", {31'h0, res1}, 32'h0);
      chk("midrst_acc", {21'h0, acc}, 32'h0);
      chk("midrst_dout", {24'h0, dout}, 32'h0);
      step(1'b1, 8'h42, 1'b0);
      chk("after_rst_dout", {24'h0, dout}, 32'h42);
      chk("after_rst_res1", {31'h0, res1}, 32'h1);
      step(1'b0, 8'h0, 1'b1);
      chk("after_rst_empty", {31'h0, res1}, 32'h0);

      // XOR reduction
      step1(1'b1, 8'h0F, 1'b0);
      chk("xor_acc1", {21'h0, acc1}, 32'h0F);
      step1(1'b1, 8'hF0, 1'b0);
      step1(1'b1, 8'hFF, 1'b0);
      chk("xor_acc3", {21'h0, acc1}, 32'h0);
      chk("xor_res2_zero", {31'h0, res2_1}, 32'h0);
      chk("xor_head", {24'h0, dout1}, 32'h0F);
      step1(1'b0, 8'h0, 1'b1);
      chk("xor_acc_pop", {21'h0, acc1}, 32'h0F);
      chk("xor_res2_set", {31'h0, res2_1}, 32'h1);
      chk("xor_dout_pop", {24'h0, dout1}, 32'hF0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/io_simple_module_param.md
Name: io_simple_module_param

Overview:
Parametrised successor of the fixed 8-bit io_simple_module_ansi. It keeps the same port family (clk, rst, en, data, res1, res2, fdbk) and generalises the data width. It adds a DEPTH-entry sample buffer with a read handshake and a running reduction (sum or XOR) over the buffered samples, with a threshold flag. It sits between a sample producer that strobes en and a consumer that drains with rd.

Parameters:
WIDTH, 8, sample width in bits (>=1)
DEPTH, 4, buffer entries; power of two, >=2
MODE, 0, reduction over buffered samples: 0 = unsigned sum, 1 = bitwise XOR
THRESH, 16, res2 compare value; width ACC_W (derived localparam ACC_W = WIDTH + $clog2(DEPTH) + 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
en  input  1  push strobe; qualifies data
data  input  WIDTH  sample to push
rd  input  1  pop request from consumer
dout  output  WIDTH  head-of-buffer sample; valid while res1=1
res1  output  1  buffer not empty (output valid)
res2  output  1  acc >= THRESH (MODE 0); acc != 0 (MODE 1)
fdbk  output  1  buffer full (backpressure to producer)
acc  output  ACC_W  running reduction over current buffer contents
ovf  output  1  sticky: push attempted while full

Behaviour:
- Reset: synchronous, active-low. Sampled on the rising clk edge while rst=0. All of the following are cleared: dout=0, res1=0, res2=0, fdbk=0, acc=0, ovf=0, count=0, pointers=0, state=EMPTY. Memory contents are not cleared.
- A push is accepted when en=1 and fdbk=0 at the edge. data is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- A pop is accepted when rd=1 and res1=1 at the edge. rd_ptr increments modulo DEPTH. rd while empty is ignored; it has no effect and sets no flag.
- Simultaneous push and pop in PARTIAL: both occur, and count is unchanged.
- When FULL, a push is refused even if a pop occurs in the same cycle, because fdbk is registered. The pop still occurs.
- When EMPTY, a simultaneous rd is ignored and the push proceeds.
- en=1 while fdbk=1 sets ovf=1. ovf stays set until reset.
- State machine (registered; outputs decoded from state):
  - EMPTY: res1=0, fdbk=0.
  - PARTIAL: res1=1, fdbk=0.
  - FULL: res1=0→1 as count>0, fdbk=1 (i.e. res1=1, fdbk=1).
  - Transitions: EMPTY→PARTIAL on push (→FULL never directly, since DEPTH>=2). PARTIAL→FULL when a push without pop makes count=DEPTH. PARTIAL→EMPTY when a pop without push makes count=0. FULL→PARTIAL on pop. Otherwise hold.
- dout is first-word-fall-through. It shows mem[rd_ptr] from the registered pointer and updates in the cycle after a push into EMPTY. Latency from push edge to res1=1 is 1 cycle.
- acc update on each accepted operation, in the same edge:
  - MODE 0: acc += data on push, acc -= dout on pop; both apply when simultaneous. Unsigned, ACC_W wide, which cannot overflow since the maximum is DEPTH*(2^WIDTH-1).
  - MODE 1: acc ^= data on push, acc ^= dout on pop; upper ACC_W-WIDTH bits stay 0.
- res2 is combinational from the registered acc. It changes in the same cycle acc changes.
- If reset asserts mid-operation, the buffer is discarded and acc=0. A push presented in the reset cycle is dropped.

Test Plan:
- Reset then idle: hold rst=0 two cycles, release, run 5 idle cycles -> all outputs 0, state EMPTY.
- Fill and drain, WIDTH=8 DEPTH=4 MODE=0: push 3,5,7,9 on consecutive cycles -> fdbk=1 after 4th edge, acc=24, res2=1. Then rd 4 cycles -> dout sequence 3,5,7,9, acc 21,16,9,0, res1=0 at end.
- Overflow: from FULL, en=1 data=0xFF with rd=0 -> contents unchanged, acc unchanged, ovf=1 and stays 1 after draining.
- Simultaneous push and pop in PARTIAL (contents 10,20): en=1 data=30, rd=1 -> dout=20 next cycle, count stays 2, acc=50. Same cycle while FULL -> pop occurs, push dropped, ovf=1.
- MODE=1: push 0x0F, 0xF0, 0xFF -> acc=0x00, res2=0. Pop one -> acc=0x0F, res2=1.
- Reset mid-fill: after 2 pushes, assert rst=0 one cycle with en=1 -> res1=0, acc=0. The first push after release appears at dout 1 cycle later.
